// File: rtl/aes_block_packer_pkg.sv
// Shared AES constants: cipher widths, block geometry and the default pad byte,
// plus the helper that tells the packer which byte lanes to pad.
package aes_block_packer_pkg;

    localparam int AES_KEY_W       = 128;
    localparam int AES_BLOCK_W     = 128;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_IDX_W       = 4;

    localparam logic [7:0] AES_PAD_BYTE = 8'h20;

    // Lane k is padded when it sits after the byte being written at idx
    function automatic logic [AES_BLOCK_BYTES-1:0] pad_mask(input logic [AES_IDX_W-1:0] idx);
        logic [AES_BLOCK_BYTES-1:0] mask;
        mask = '0;
        for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
            mask[k] = (k > int'(idx));
        end
        return mask;
    endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Collects plaintext bytes MSB-first into 128-bit AES blocks, pads the final
// partial block of a message and holds each block until the cipher takes it.
module aes_block_packer
    import aes_block_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = AES_PAD_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [AES_BLOCK_W-1:0] block_out,
    output logic                   block_valid,
    input  logic                   block_ready,
    output logic                   block_last,
    output logic [15:0]            block_count
);

    localparam logic [0:0] STATE_COLLECT = 1'b0;
    localparam logic [0:0] STATE_HOLD    = 1'b1;

    logic [0:0]                 state;
    logic [AES_IDX_W-1:0]       idx;
    logic [AES_BLOCK_BYTES-1:0] fill_mask;
    logic [AES_BLOCK_W-1:0]     packed_next;
    logic                       byte_take;
    logic                       block_take;
    logic                       block_done;

    assign in_ready    = (state == STATE_COLLECT);
    assign block_valid = (state == STATE_HOLD);
    assign byte_take   = in_valid & in_ready;
    assign block_take  = block_valid & block_ready;
    assign block_done  = (idx == 4'd15) | in_last;

    // Next block image: the incoming byte at lane idx, and on a closing byte every later lane padded
    always_comb begin
        fill_mask   = pad_mask(idx);
        packed_next = block_out;
        for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
            if (4'(k) == idx) begin
                packed_next[AES_BLOCK_W-1-8*k -: 8] = in_byte;
            end else if (in_last && fill_mask[k]) begin
                packed_next[AES_BLOCK_W-1-8*k -: 8] = PAD_BYTE;
            end
        end
    end

    // Collect/hold handshake; reset drops any partial or held block without counting it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STATE_COLLECT;
            idx         <= '0;
            block_out   <= '0;
            block_last  <= 1'b0;
            block_count <= '0;
        end else begin
            case (state)
                STATE_COLLECT: begin
                    if (byte_take) begin
                        block_out <= packed_next;
                        if (block_done) begin
                            idx        <= '0;
                            block_last <= in_last;
                            state      <= STATE_HOLD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                STATE_HOLD: begin
                    if (block_take) begin
                        state       <= STATE_COLLECT;
                        block_count <= block_count + 16'd1;
                        block_last  <= 1'b0;
                    end
                end
                default: begin
                    state <= STATE_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Randomized and directed bench for aes_block_packer, scored against a
// byte-queue model of how messages split into padded 16-byte blocks.
module tb_aes_block_packer;

    localparam logic [7:0] PAD = 8'h20;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic         block_last;
    logic [15:0]  block_count;

    logic         in_ready0;
    logic [127:0] block_out0;
    logic         block_valid0;
    logic         block_last0;
    logic [15:0]  block_count0;

    int assert_count = 0;
    int fail_count   = 0;
    int ready_mode   = 0;
    int preload_seq  = 0;

    aes_block_packer dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last),
        .block_count (block_count)
    );

    aes_block_packer #(.PAD_BYTE(8'h00)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready0),
        .block_out   (block_out0),
        .block_valid (block_valid0),
        .block_ready (block_ready),
        .block_last  (block_last0),
        .block_count (block_count0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: accepted bytes build up a message slice; a slice closes at 16 bytes or on in_last
    logic [7:0]  cur[$];
    blk_t        exp_q[$];
    logic [15:0] model_count = 16'h0000;
    bit          live = 1'b0;
    int          preload_seen = 0;

    always @(negedge clk) begin
        blk_t nb;
        bit   holding;
        if (preload_seen != preload_seq) begin
            model_count  = 16'hFFFF;
            preload_seen = preload_seq;
        end
        if (live) begin
            checkOutput("block_valid", {127'b0, block_valid}, {127'b0, exp_q.size() != 0});
            checkOutput("in_ready", {127'b0, in_ready}, {127'b0, exp_q.size() == 0});
            checkOutput("block_count", {112'b0, block_count}, {112'b0, model_count});
            if (exp_q.size() != 0 && block_valid) begin
                checkOutput("block_out", block_out, exp_q[0].data);
                checkOutput("block_last", {127'b0, block_last}, {127'b0, exp_q[0].last});
            end
        end
        if (rst) begin
            cur.delete();
            exp_q.delete();
            model_count = 16'h0000;
            live = 1'b1;
        end else if (live) begin
            holding = (exp_q.size() != 0);
            if (holding && block_ready) begin
                void'(exp_q.pop_front());
                model_count = model_count + 16'd1;
            end
            if (!holding && in_valid) begin
                cur.push_back(in_byte);
                if (in_last || cur.size() == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        nb.data[127-8*k -: 8] = (k < cur.size()) ? cur[k] : PAD;
                    end
                    nb.last = in_last;
                    exp_q.push_back(nb);
                    cur.delete();
                end
            end
        end
    end

    // Random downstream backpressure when the bench is in random mode
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0) block_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one byte and hold it until the accepting edge; leaves junk on the bus afterwards
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        int budget;
        budget   = 0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) checkOutput("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_byte  = 8'($urandom);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic releaseBlock();
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        block_ready = 1'b0;
    endtask

    task automatic sendHello();
        logic [7:0] msg [12];
        msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21};
        for (int i = 0; i < 12; i++) applyStimulus(msg[i], i == 11);
    endtask

    initial begin
        logic [15:0] base;
        int          len;
        int          budget;

        @(posedge clk);
        #1;
        pulseReset();
        checkOutput("reset_in_ready", {127'b0, in_ready}, 128'd1);
        checkOutput("reset_block_valid", {127'b0, block_valid}, 128'd0);
        checkOutput("reset_block_count", {112'b0, block_count}, 128'd0);

        // Hello World with space padding, visible one cycle after the last byte
        sendHello();
        checkOutput("hello_valid", {127'b0, block_valid}, 128'd1);
        checkOutput("hello_block", block_out, 128'h48656c6c6f20576f726c642120202020);
        checkOutput("hello_last", {127'b0, block_last}, 128'd1);
        releaseBlock();

        // 32 bytes back-to-back with the cipher always ready
        pulseReset();
        block_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'(i), i == 31);
            if (i == 15) begin
                checkOutput("b2b_block1", block_out, 128'h000102030405060708090a0b0c0d0e0f);
                checkOutput("b2b_last1", {127'b0, block_last}, 128'd0);
            end
        end
        checkOutput("b2b_block2", block_out, 128'h101112131415161718191a1b1c1d1e1f);
        checkOutput("b2b_last2", {127'b0, block_last}, 128'd1);
        @(posedge clk);
        #1;
        block_ready = 1'b0;
        checkOutput("b2b_count", {112'b0, block_count}, 128'd2);

        // Exactly 16 bytes held against backpressure: stable, one handoff on release
        base = block_count;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'hC0 + i), i == 15);
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_valid", {127'b0, block_valid}, 128'd1);
            checkOutput("hold_in_ready", {127'b0, in_ready}, 128'd0);
            checkOutput("hold_block", block_out, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
            @(posedge clk);
            #1;
        end
        releaseBlock();
        @(posedge clk);
        #1;
        checkOutput("hold_one_handoff", {112'b0, block_count}, {112'b0, base + 16'd1});

        // Single byte padded with zeros in the PAD_BYTE=0 instance
        applyStimulus(8'hAB, 1'b1);
        checkOutput("pad0_block", block_out0, 128'hAB000000000000000000000000000000);
        checkOutput("pad20_block", block_out, 128'hAB202020202020202020202020202020);
        releaseBlock();

        // Reset mid-block leaves no trace
        for (int i = 0; i < 7; i++) applyStimulus(8'(8'h90 + i), 1'b0);
        pulseReset();
        sendHello();
        checkOutput("rst_hello_block", block_out, 128'h48656c6c6f20576f726c642120202020);
        checkOutput("rst_hello_last", {127'b0, block_last}, 128'd1);
        releaseBlock();
        checkOutput("rst_hello_count", {112'b0, block_count}, 128'd1);

        // Counter wrap from FFFF
        force dut.block_count = 16'hFFFF;
        preload_seq++;
        @(posedge clk);
        #1;
        release dut.block_count;
        applyStimulus(8'h55, 1'b1);
        releaseBlock();
        checkOutput("count_wrap", {112'b0, block_count}, 128'd0);

        // Random messages with random gaps and backpressure
        ready_mode = 1;
        for (int m = 0; m < 30; m++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(8'($urandom), i == len - 1);
            end
        end
        ready_mode = 0;
        #2;
        block_ready = 1'b1;
        budget = 0;
        while (block_valid && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("drain", {127'b0, block_valid}, 128'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 Parameter PAD_BYTE, default 8'h20, is the byte used to fill a final partial block.
REQ-002 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port in_byte, input, 8, plaintext byte.
REQ-005 Port in_valid, input, 1, in_byte is valid this cycle.
REQ-006 Port in_last, input, 1, qualifies in_byte as the final byte of a message; meaningful only with in_valid.
REQ-007 Port in_ready, output, 1, packer accepts a byte this cycle.
REQ-008 Port block_out, output, 128, packed block; feeds the cipher datain.
REQ-009 Port block_valid, output, 1, block_out holds a complete block.
REQ-010 Port block_ready, input, 1, downstream accepts block_out this cycle.
REQ-011 Port block_last, output, 1, block_out is the final block of a message.
REQ-012 Port block_count, output, 16, number of blocks handed off since reset.

Function
REQ-013 A byte transfers when in_valid and in_ready are both high on a rising edge; a block transfers when block_valid and block_ready are both high.
REQ-014 FSM states: COLLECT (in_ready=1, block_valid=0) and HOLD (in_ready=0, block_valid=1); no other states.
REQ-015 Byte index idx (4 bits) counts accepted bytes in the current block, 0..15.
REQ-016 Packing is MSB-first: byte k of a block goes to block_out[127-8k -: 8], so the first byte lands in [127:120].
REQ-017 In COLLECT, on a byte transfer with idx=15: write the byte, set idx=0, set block_last=in_last, go to HOLD.
REQ-018 In COLLECT, on a byte transfer with in_last=1 and idx<15: write the byte, fill every byte position above idx with PAD_BYTE in the same edge, set idx=0, block_last=1, go to HOLD.
REQ-019 In COLLECT, on a byte transfer with in_last=0 and idx<15: write the byte and increment idx.
REQ-020 A message whose length is a multiple of 16 produces no extra padding block; block_last is set on its 16th byte.
REQ-021 block_valid rises on the cycle after the completing byte transfer (latency 1 cycle from last accepted byte to block_valid).
REQ-022 In HOLD, block_out and block_last stay stable until the block transfer; in_valid is ignored.
REQ-023 On a block transfer in HOLD: go to COLLECT, increment block_count (wrapping 16'hFFFF -> 0), clear block_last; in_ready is high the following cycle (no same-cycle bypass).
REQ-024 Byte positions not yet written in COLLECT are don't-care; block_out is only defined while block_valid=1.
REQ-025 in_last with in_valid=0 has no effect.

Reset
REQ-026 On rst=1 at a rising edge: state=COLLECT, idx=0, block_out=0, block_valid=0, block_last=0, block_count=0; in_ready=1 on the cycle after the reset edge.
REQ-027 Reset mid-block or in HOLD discards the partial or held block without a handoff and without incrementing block_count.
REQ-028 rst has priority over any simultaneous byte or block transfer.

Structure
REQ-029 AES_BLOCK_BYTES=16, AES_BLOCK_W=128 and the default pad byte constant belong in the shared AES package, alongside the cipher's widths.
REQ-030 Single flat module with no sub-modules; the padding mask is a combinational function of idx.
REQ-031 Implementation target is 120-400 lines of RTL.

Verification
REQ-032 Send the 12 bytes "Hello World!" (48 65 6c 6c 6f 20 57 6f 72 6c 64 21) with in_last on 8'h21 -> block_out=128'h48656c6c6f20576f726c642120202020 with block_last=1, one cycle after the last byte.
REQ-033 Send 32 bytes 00..1F back-to-back with block_ready held high and in_last on 1F -> block 1 is 128'h000102...0F with block_last=0, block 2 is 128'h101112...1F with block_last=1, and block_count=2.
REQ-034 Send 16 bytes with in_last on the 16th and block_ready held low for 5 cycles -> block_valid stays high and in_ready stays low, block_out is stable throughout, and exactly one handoff occurs on release.
REQ-035 Send 1 byte 8'hAB with in_last and PAD_BYTE=8'h00 -> block_out=128'hAB000000000000000000000000000000.
REQ-036 Send 7 bytes, then assert rst for one cycle, then send "Hello World!" -> the output matches REQ-032 exactly, the earlier bytes leave no trace, and block_count=1.
REQ-037 Preload block_count to 16'hFFFF through forced handoffs, then complete one more block -> block_count=16'h0000.
